// File: rtl/dtw_pkg.sv
// Shared types for the DTW sample FIFO scheduler: source tags and read-sequencer states.
package dtw_pkg;

    localparam int DTW_DATA_WIDTH = 32;

    typedef logic src_t;
    localparam src_t SRC_REF  = 1'b0;
    localparam src_t SRC_LIVE = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        CAPT,
        HOLD
    } rd_state_t;

endpackage

// File: rtl/dtw_fifo_sched_rr_arb2.sv
// Two-way round-robin arbiter: combinational one-hot grant gated by allow,
// a simultaneous request goes to the requester that did not win last.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       allow,
    output logic [1:0] gnt
);
    logic last_q;

    always_comb begin
        gnt = 2'b00;
        if (allow) begin
            case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = last_q ? 2'b01 : 2'b10;
                default: gnt = 2'b00;
            endcase
        end
    end

    // Reset to 1 so requester 0 wins the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= 1'b1;
        end else if (|gnt) begin
            last_q <= gnt[1];
        end
    end

endmodule

// File: rtl/fifo.sv
// Generic single-clock FIFO with registered read data (valid the cycle after rden).
// Writes when full and reads when empty are ignored.
module fifo #(
    parameter int DEPTH = 20,
    parameter int WIDTH = 33
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wren,
    input  logic [WIDTH-1:0] wdata,
    input  logic             rden,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    cnt_q;
    logic             do_wr, do_rd;

    assign full  = (cnt_q == CW'(DEPTH));
    assign empty = (cnt_q == '0);
    assign do_wr = wren && !full;
    assign do_rd = rden && !empty;

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            rdata    <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr_q <= (wr_ptr_q == AW'(DEPTH - 1)) ? '0 : wr_ptr_q + AW'(1);
            end
            if (do_rd) begin
                rdata    <= mem_q[rd_ptr_q];
                rd_ptr_q <= (rd_ptr_q == AW'(DEPTH - 1)) ? '0 : rd_ptr_q + AW'(1);
            end
            case ({do_wr, do_rd})
                2'b10:   cnt_q <= cnt_q + CW'(1);
                2'b01:   cnt_q <= cnt_q - CW'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/dtw_fifo_sched.sv
// Shares one DTW sample FIFO between reference and live producers; reads are sequenced
// into a valid/ready stream, out_valid three edges after rden, one word per four cycles.
module dtw_fifo_sched
    import dtw_pkg::*;
#(
    parameter int DEPTH      = 20,
    parameter int DATA_WIDTH = DTW_DATA_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic [1:0]                 req,
    input  logic [DATA_WIDTH-1:0]      data0,
    input  logic [DATA_WIDTH-1:0]      data1,
    output logic [1:0]                 gnt,
    output logic                       fifo_wren,
    output logic [DATA_WIDTH:0]        fifo_wdata,
    output logic                       fifo_rden,
    input  logic [DATA_WIDTH:0]        fifo_rdata,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_WIDTH-1:0]      out_data,
    output logic                       out_src,
    output logic [$clog2(DEPTH+1)-1:0] level
);
    localparam int               LVL_W   = $clog2(DEPTH + 1);
    localparam logic [LVL_W-1:0] LVL_MAX = LVL_W'(DEPTH);

    rd_state_t             rd_state_q;
    logic [LVL_W-1:0]      level_q, level_d;
    logic                  out_valid_q;
    logic [DATA_WIDTH-1:0] out_data_q;
    src_t                  out_src_q;
    logic                  rd_fire;
    logic                  wr_allow;

    // Reads win the shared port; writes are also held off while reset is asserted.
    assign rd_fire  = (rd_state_q == IDLE) && en && (level_q != '0) && !out_valid_q;
    assign wr_allow = !rst && en && (level_q < LVL_MAX) && !rd_fire;

    rr_arb2 u_arb (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .allow (wr_allow),
        .gnt   (gnt)
    );

    assign fifo_wren = |gnt;
    assign fifo_rden = rd_fire;

    always_comb begin
        fifo_wdata = '0;
        if (gnt[1]) begin
            fifo_wdata = {SRC_LIVE, data1};
        end else if (gnt[0]) begin
            fifo_wdata = {SRC_REF, data0};
        end
    end

    always_comb begin
        level_d = level_q;
        if (fifo_wren) begin
            level_d = level_q + LVL_W'(1);
        end else if (fifo_rden) begin
            level_d = level_q - LVL_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_state_q  <= IDLE;
            level_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= SRC_REF;
        end else begin
            level_q <= level_d;
            case (rd_state_q)
                IDLE: if (rd_fire) rd_state_q <= WAIT;
                WAIT: rd_state_q <= CAPT;
                CAPT: begin
                    out_data_q  <= fifo_rdata[DATA_WIDTH-1:0];
                    out_src_q   <= src_t'(fifo_rdata[DATA_WIDTH]);
                    out_valid_q <= 1'b1;
                    rd_state_q  <= HOLD;
                end
                HOLD: begin
                    if (out_valid_q && out_ready) begin
                        out_valid_q <= 1'b0;
                        rd_state_q  <= IDLE;
                    end
                end
                default: rd_state_q <= IDLE;
            endcase
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_src   = out_src_q;
    assign level     = level_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(fifo_wren && fifo_rden));
            assert (!(fifo_wren && level_q == LVL_MAX));
            assert (!(fifo_rden && level_q == '0));
        end
    end

endmodule

// File: tb/tb_dtw_fifo_sched.sv
// Directed bench for dtw_fifo_sched driving a real fifo instance.
module tb_dtw_fifo_sched;
    localparam int DEPTH = 20;
    localparam int DW    = 32;
    localparam int LW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          en = 1'b1;
    logic          out_ready = 1'b0;
    logic [1:0]    req = 2'b00;
    logic [DW-1:0] data0 = '0;
    logic [DW-1:0] data1 = '0;
    logic [1:0]    gnt;
    logic          fifo_wren, fifo_rden, out_valid, out_src, fifo_full, fifo_empty;
    logic [DW:0]   fifo_wdata, fifo_rdata;
    logic [DW-1:0] out_data;
    logic [LW-1:0] level;

    always #5 clk = ~clk;

    dtw_fifo_sched #(.DEPTH(DEPTH), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst), .en(en), .req(req), .data0(data0), .data1(data1),
        .gnt(gnt), .fifo_wren(fifo_wren), .fifo_wdata(fifo_wdata), .fifo_rden(fifo_rden),
        .fifo_rdata(fifo_rdata), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_src(out_src), .level(level)
    );

    fifo #(.DEPTH(DEPTH), .WIDTH(DW + 1)) u_fifo (
        .clk(clk), .rst_n(~rst), .wren(fifo_wren), .wdata(fifo_wdata),
        .rden(fifo_rden), .rdata(fifo_rdata), .full(fifo_full), .empty(fifo_empty)
    );

    int         n_chk = 0;
    int         n_fail = 0;
    bit         both_seen = 1'b0;
    int         ng, no, cnt0, cnt1;
    bit         flag;
    logic [1:0] g;
    logic [1:0] exp_g [4];
    logic [DW-1:0] exp_d [4];
    logic       exp_s [4];

    always @(negedge clk) begin
        if (!rst && fifo_wren && fifo_rden) both_seen = 1'b1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; req = 2'b00; en = 1'b1; out_ready = 1'b0;
        #1;
        step();
        rst = 1'b0;
    endtask

    task automatic wr(input bit s, input logic [DW-1:0] d, input string tag);
        bit got = 1'b0;
        if (s) data1 = d; else data0 = d;
        req[s] = 1'b1;
        for (int i = 0; i < 40 && !got; i++) begin
            #1;
            got = gnt[s];
            step();
        end
        req[s] = 1'b0;
        check(tag, got, 1);
    endtask

    task automatic expect_out(input logic [DW-1:0] d, input bit s, input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            #1;
            if (out_valid) begin
                seen = 1'b1;
                check({tag, "_data"}, out_data, d);
                check({tag, "_src"}, out_src, s);
            end
            step();
        end
        check({tag, "_seen"}, seen, 1);
    endtask

    initial begin
        // Reset state, with both requests high to prove grants are held off.
        #1 rst = 1'b1;
        req = 2'b11;
        #1;
        check("rst_gnt", gnt, 0);
        check("rst_wren", fifo_wren, 0);
        check("rst_rden", fifo_rden, 0);
        check("rst_wdata", fifo_wdata, 0);
        check("rst_ovalid", out_valid, 0);
        check("rst_odata", out_data, 0);
        check("rst_osrc", out_src, 0);
        check("rst_level", level, 0);
        req = 2'b00;
        step();
        rst = 1'b0;

        // Single word latency.
        req = 2'b01; data0 = 32'hA5;
        #1;
        check("t1_gnt", gnt, 2'b01);
        check("t1_wren", fifo_wren, 1);
        check("t1_wdata", fifo_wdata, 33'h0_0000_00A5);
        step();
        req = 2'b00;
        #1;
        check("t1_level1", level, 1);
        check("t1_rden", fifo_rden, 1);
        step(); #1;
        check("t1_level0", level, 0);
        step(); #1;
        check("t1_ovalid_early", out_valid, 0);
        step(); #1;
        check("t1_ovalid", out_valid, 1);
        check("t1_odata", out_data, 32'hA5);
        check("t1_osrc", out_src, 0);
        out_ready = 1'b1;
        step(); #1;
        check("t1_drained", out_valid, 0);

        // Round robin with both requesters held.
        do_reset();
        out_ready = 1'b1;
        exp_g = '{2'b01, 2'b10, 2'b01, 2'b10};
        exp_d = '{32'h100, 32'h200, 32'h101, 32'h201};
        exp_s = '{1'b0, 1'b1, 1'b0, 1'b1};
        ng = 0; no = 0; cnt0 = 0; cnt1 = 0;
        data0 = 32'h100; data1 = 32'h200; req = 2'b11;
        for (int cyc = 0; cyc < 80 && (ng < 4 || no < 4); cyc++) begin
            #1;
            g = gnt;
            if (g != 2'b00 && ng < 4) begin
                check($sformatf("rr_gnt%0d", ng), g, exp_g[ng]);
                ng++;
            end
            if (out_valid && out_ready && no < 4) begin
                check($sformatf("rr_src%0d", no), out_src, exp_s[no]);
                check($sformatf("rr_data%0d", no), out_data, exp_d[no]);
                no++;
            end
            step();
            if (g[0]) begin cnt0++; data0 = data0 + 1; if (cnt0 == 2) req[0] = 1'b0; end
            if (g[1]) begin cnt1++; data1 = data1 + 1; if (cnt1 == 2) req[1] = 1'b0; end
        end
        check("rr_grants", ng, 4);
        check("rr_outs", no, 4);

        // Fill: one word parks on the output, twenty fill the FIFO, the next stalls.
        do_reset();
        out_ready = 1'b0;
        for (int k = 0; k < 21; k++) wr(1'b1, 32'h300 + k, $sformatf("fill_wr%0d", k));
        #1;
        check("full_level", level, 20);
        check("full_ovalid", out_valid, 1);
        check("full_odata", out_data, 32'h300);
        req[1] = 1'b1; data1 = 32'h3FF;
        flag = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step(); #1;
            if (gnt != 2'b00) flag = 1'b1;
        end
        check("full_stall", flag, 0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        #1;
        check("rdpri_rden", fifo_rden, 1);
        check("rdpri_gnt", gnt, 0);
        step(); #1;
        check("free_level", level, 19);
        check("free_gnt", gnt, 2'b10);
        step();
        req = 2'b00;
        #1;
        check("refill_level", level, 20);
        out_ready = 1'b1;
        expect_out(32'h301, 1'b1, "fill_out1");
        expect_out(32'h302, 1'b1, "fill_out2");

        // en dropped while a read is in WAIT.
        do_reset();
        out_ready = 1'b0;
        wr(1'b0, 32'hA0, "en_wrA");
        wr(1'b0, 32'hB0, "en_wrB");
        wr(1'b0, 32'hC0, "en_wrC");
        repeat (4) step();
        #1;
        check("en_level2", level, 2);
        check("en_odataA", out_data, 32'hA0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        #1;
        check("en_rden", fifo_rden, 1);
        step();
        en = 1'b0; req[0] = 1'b1; data0 = 32'hD0;
        #1;
        check("en_wait_gnt", gnt, 0);
        step(); #1;
        check("en_capt_gnt", gnt, 0);
        step(); #1;
        check("en_ovalid", out_valid, 1);
        check("en_odataB", out_data, 32'hB0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        #1;
        check("en_hold_done", out_valid, 0);
        check("en_level1", level, 1);
        flag = fifo_rden | (|gnt);
        for (int i = 0; i < 3; i++) begin
            step(); #1;
            if (fifo_rden || gnt != 2'b00) flag = 1'b1;
        end
        check("en_quiet", flag, 0);
        en = 1'b1;
        #1;
        check("en_resume_rden", fifo_rden, 1);
        check("en_resume_gnt", gnt, 0);
        step(); #1;
        check("en_resume_gnt2", gnt, 2'b01);
        step();
        req = 2'b00;
        #1;
        check("en_level_end", level, 1);
        out_ready = 1'b1;
        expect_out(32'hC0, 1'b0, "en_outC");
        expect_out(32'hD0, 1'b0, "en_outD");

        // Reset asserted while the sequencer is in CAPT with five words queued.
        do_reset();
        out_ready = 1'b0;
        for (int k = 0; k < 7; k++) wr(1'b0, 32'h500 + k, $sformatf("rst_wr%0d", k));
        repeat (4) step();
        #1;
        check("mid_level6", level, 6);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        step();
        step(); #1;
        check("mid_level5", level, 5);
        req = 2'b01; data0 = 32'h777;
        rst = 1'b1;
        #1;
        check("mid_rst_level", level, 0);
        check("mid_rst_gnt", gnt, 0);
        check("mid_rst_ovalid", out_valid, 0);
        step();
        rst = 1'b0;
        #1;
        check("post_rst_gnt", gnt, 2'b01);
        step();
        req = 2'b00;
        out_ready = 1'b1;
        expect_out(32'h777, 1'b0, "post_rst_out");
        #1;
        check("post_rst_level", level, 0);

        check("port_exclusive", both_seen, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
